// File: rtl/demux_32bit_buf.sv
// demux_32bit_buf
//   One-to-two router with a small FIFO per output channel. Each accepted
//   producer word is steered by `control` (0 -> out1, 1 -> out2) into that
//   channel's FIFO, so a stalled consumer never blocks the other channel.
//
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   control                 route select, sampled only in the push cycle
//   in_valid/in_data        producer word
//   in_ready                selected FIFO is not full (combinational)
//   outK_valid/outK_data    FIFO K non-empty / head entry
//   outK_ready              consumer K accepts the head entry
//   outK_count              occupancy of FIFO K
module demux_32bit_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       control,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out1_valid,
  output logic [WIDTH-1:0]           out1_data,
  input  logic                       out1_ready,
  output logic                       out2_valid,
  output logic [WIDTH-1:0]           out2_data,
  input  logic                       out2_ready,
  output logic [$clog2(DEPTH):0]     out1_count,
  output logic [$clog2(DEPTH):0]     out2_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Index 0 is the out1 FIFO, index 1 is the out2 FIFO.
  logic [WIDTH-1:0] mem_q  [2][DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    rptr_q [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  logic [1:0]       push;
  logic [1:0]       pop;

  // Full/empty come from the occupancy counts, never from pointer compare.
  assign in_ready   = control ? (cnt_q[1] != FULL) : (cnt_q[0] != FULL);
  assign out1_valid = (cnt_q[0] != '0);
  assign out2_valid = (cnt_q[1] != '0);
  assign out1_data  = mem_q[0][rptr_q[0]];
  assign out2_data  = mem_q[1][rptr_q[1]];
  assign out1_count = cnt_q[0];
  assign out2_count = cnt_q[1];

  always_comb begin
    push    = '0;
    pop     = '0;
    push[0] = in_valid & in_ready & ~control;
    push[1] = in_valid & in_ready &  control;
    pop[0]  = out1_valid & out1_ready;
    pop[1]  = out2_valid & out2_ready;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      cnt_d[ch] = cnt_q[ch];
      if (push[ch] && !pop[ch])
        cnt_d[ch] = cnt_q[ch] + 1'b1;
      else if (!push[ch] && pop[ch])
        cnt_d[ch] = cnt_q[ch] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        wptr_q[ch] <= '0;
        rptr_q[ch] <= '0;
        cnt_q[ch]  <= '0;
        for (int unsigned i = 0; i < DEPTH; i++)
          mem_q[ch][i] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (push[ch]) begin
          mem_q[ch][wptr_q[ch]] <= in_data;
          wptr_q[ch]            <= wptr_q[ch] + 1'b1;
        end
        if (pop[ch])
          rptr_q[ch] <= rptr_q[ch] + 1'b1;
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

endmodule

// File: tb/tb_demux_32bit_buf.sv
module tb_demux_32bit_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             control;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out1_valid;
  logic [WIDTH-1:0] out1_data;
  logic             out1_ready;
  logic             out2_valid;
  logic [WIDTH-1:0] out2_data;
  logic             out2_ready;
  logic [CW-1:0]    out1_count;
  logic [CW-1:0]    out2_count;

  demux_32bit_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .control    (control),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .out2_valid (out2_valid),
    .out2_data  (out2_data),
    .out2_ready (out2_ready),
    .out1_count (out1_count),
    .out2_count (out2_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per channel holding the words in flight.
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  bit          m_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_rdy;
    exp_rdy = control ? (q2.size() != DEPTH) : (q1.size() != DEPTH);
    chk({tag, ".in_ready"},   32'(in_ready),   32'(exp_rdy));
    chk({tag, ".out1_valid"}, 32'(out1_valid), 32'(q1.size() != 0));
    chk({tag, ".out2_valid"}, 32'(out2_valid), 32'(q2.size() != 0));
    chk({tag, ".out1_count"}, 32'(out1_count), 32'(q1.size()));
    chk({tag, ".out2_count"}, 32'(out2_count), 32'(q2.size()));
    if (q1.size() != 0) chk({tag, ".out1_data"}, out1_data, q1[0]);
    if (q2.size() != 0) chk({tag, ".out2_data"}, out2_data, q2[0]);
  endtask

  // One clock cycle: apply inputs, predict push/pop from the model state,
  // advance through the edge, update the model, then compare.
  task automatic cyc(input string tag, input logic v, input logic c,
                     input logic [31:0] d, input logic r1, input logic r2);
    bit p1, p2;
    in_valid = v; control = c; in_data = d; out1_ready = r1; out2_ready = r2;
    m_push = v && (c ? (q2.size() < DEPTH) : (q1.size() < DEPTH));
    p1 = r1 && (q1.size() != 0);
    p2 = r2 && (q2.size() != 0);
    @(posedge clk);
    #1;
    if (p1) void'(q1.pop_front());
    if (p2) void'(q2.pop_front());
    if (m_push) begin
      if (c) q2.push_back(d);
      else   q1.push_back(d);
    end
    check_all(tag);
  endtask

  initial begin
    int idx;
    int n;
    rst_n = 1'b0; control = 1'b0; in_valid = 1'b0; in_data = '0;
    out1_ready = 1'b0; out2_ready = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset");
    chk("reset.out1_data", out1_data, 32'h0);
    chk("reset.out2_data", out2_data, 32'h0);

    // Basic route
    cyc("route1", 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("route1.out1_data_const", out1_data, 32'hDEADBEEF);
    cyc("route2", 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1);
    chk("route2.out1_valid_drop", 32'(out1_valid), 32'h0);
    chk("route2.out2_data_const", out2_data, 32'h12345678);
    cyc("route3", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("route3.out2_valid_drop", 32'(out2_valid), 32'h0);

    // Full and back-pressure
    cyc("bp1", 1'b1, 1'b0, 32'h1, 1'b0, 1'b1);
    cyc("bp2", 1'b1, 1'b0, 32'h2, 1'b0, 1'b1);
    chk("bp.full_count", 32'(out1_count), 32'd2);
    chk("bp.full_ready", 32'(in_ready), 32'd0);
    cyc("bp_blocked", 1'b1, 1'b0, 32'hBAD0BAD0, 1'b0, 1'b0);
    cyc("bp_other", 1'b1, 1'b1, 32'hA, 1'b0, 1'b0);
    chk("bp_other.out2_data_const", out2_data, 32'hA);
    chk("bp_other.out1_still", 32'(out1_count), 32'd2);
    cyc("bp_rel1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("bp_rel1.head_const", out1_data, 32'h2);
    cyc("bp_rel2", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc("bp_rel3", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Wrap-around: 10 words through out1 with toggling ready
    idx = 0;
    n = 0;
    while (idx < 10 && n < 200) begin
      cyc("wrap", 1'b1, 1'b0, 32'h100 + 32'(idx), n[0], 1'b1);
      if (m_push) idx++;
      n++;
    end
    chk("wrap.all_accepted", 32'(idx), 32'd10);
    n = 0;
    while (q1.size() != 0 && n < 20) begin
      cyc("wrap_drain", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      n++;
    end
    chk("wrap.drained", 32'(out1_count), 32'd0);

    // Simultaneous push/pop
    cyc("sim_fill", 1'b1, 1'b0, 32'h55, 1'b0, 1'b1);
    chk("sim_fill.head_const", out1_data, 32'h55);
    cyc("sim_pp", 1'b1, 1'b0, 32'h66, 1'b1, 1'b1);
    chk("sim_pp.count_const", 32'(out1_count), 32'd1);
    chk("sim_pp.head_const", out1_data, 32'h66);
    cyc("sim_drain", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      cyc("rand", 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));

    // Reset mid-operation with both FIFOs full
    n = 0;
    while ((q1.size() != DEPTH || q2.size() != DEPTH) && n < 20) begin
      cyc("rst_fill", 1'b1, (q1.size() == DEPTH), $urandom, 1'b0, 1'b0);
      n++;
    end
    chk("rst_fill.out1_full", 32'(out1_count), 32'(DEPTH));
    chk("rst_fill.out2_full", 32'(out2_count), 32'(DEPTH));
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    q1.delete();
    q2.delete();
    chk("rst_mid.out1_valid", 32'(out1_valid), 32'h0);
    chk("rst_mid.out2_valid", 32'(out2_valid), 32'h0);
    chk("rst_mid.out1_count", 32'(out1_count), 32'h0);
    chk("rst_mid.out2_count", 32'(out2_count), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel.out1_data", out1_data, 32'h0);
    chk("rst_rel.out2_data", out2_data, 32'h0);
    cyc("rst_rel1", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cyc("rst_rel2", 1'b0, 1'b1, 32'h0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
